nibble_serial_add_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit add/subtract operations by time-multiplexing a single instance of the team's 4-bit ripple-carry adder (add4). It processes one nibble per clock, least-significant first, with a registered inter-nibble carry. A start/busy/done handshake lets a wider datapath share one small adder instead of instantiating WIDTH/4 slices.

---
 rtl/nibble_serial_add_ctrl_if.sv | 28 ++
 rtl/nibble_serial_add_ctrl.sv | 158 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and operand/result bus between a requester and the
// nibble-serial add/subtract controller.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  // Requester side: issues operations and observes completion.
  modport master (
    output start, sub, cin, a_in, b_in,
    input  busy, done, result, cout, ovf
  );

  // Controller side: accepts operations and reports results.
  modport slave (
    input  start, sub, cin, a_in, b_in,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one shared 4-bit
// ripple-carry adder. One nibble is processed per clock, LSB first, with
// the inter-nibble carry held in a flop.

// 4-bit ripple-carry adder slice shared by the controller.
module add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cy_in,
  output logic [3:0] s,
  output logic       cy4
);
  // Ripple the carry through the four bit positions.
  always_comb begin
    logic c;
    c = cy_in;
    s = 4'h0;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cy4 = c;
  end
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_add_ctrl_if.slave   bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the nibbles already produced; the current nibble comes straight
  // from the adder, so the low four bits of a full-width register would
  // never be read.
  logic [WIDTH-5:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       add_s;
  logic             add_cy4;
  logic [WIDTH-1:0] sum_full;
  logic             carry_into_msb;

  add4 u_add4 (
    .x     (a_q[3:0]),
    .y     (b_q[3:0]),
    .cy_in (carry_q),
    .s     (add_s),
    .cy4   (add_cy4)
  );

  assign sum_full       = {add_s, sum_q};
  assign carry_into_msb = a_q[3] ^ b_q[3] ^ add_s[3];

  // Next-state logic: load on accepted start, shift one nibble per RUN
  // cycle, and latch the visible result only on the last nibble.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.sub ? ~bus.b_in : bus.b_in;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = sum_full[WIDTH-1:4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = add_cy4;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = sum_full;
          cout_d   = add_cy4;
          ovf_d    = add_cy4 ^ carry_into_msb;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16) using a
// scoreboard of expected results filled when an operation is launched.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   done_count;
  exp_t sb_q[$];

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model using plain full-width arithmetic.
  function automatic exp_t computeExp(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic cin, input logic sub);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb       = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    e.result = full[WIDTH-1:0];
    e.cout   = full[WIDTH];
    e.ovf    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drive one request for a single edge (E0), optionally record the
  // expected result, then scramble the operands to prove they were captured.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input bit push_exp);
    @(negedge clk);
    bus_if.a_in  = a;
    bus_if.b_in  = b;
    bus_if.cin   = cin;
    bus_if.sub   = sub;
    bus_if.start = 1'b1;
    @(posedge clk);
    if (push_exp) sb_q.push_back(computeExp(a, b, cin, sub));
    #1;
    bus_if.start = 1'b0;
    bus_if.a_in  = WIDTH'($urandom);
    bus_if.b_in  = WIDTH'($urandom);
    bus_if.cin   = 1'($urandom);
    bus_if.sub   = 1'($urandom);
  endtask

  // Wait (bounded) for done, counting busy cycles; returns at a negedge
  // where done is high.
  task automatic waitDone(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.done) seen = 1'b1;
      else if (bus_if.busy) busy_cycles++;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Full operation: launch, wait for completion, check latency and pulse width.
  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input string tag);
    int bc;
    applyStimulus(a, b, cin, sub, 1'b1);
    waitDone(bc);
    checkOutput({tag, "_busy_len"}, 32'(bc), 32'd4);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'd0, bus_if.done}, 32'd0);
  endtask

  // Scoreboard monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      exp_t e;
      done_count++;
      checkOutput("busy_with_done", {31'd0, bus_if.busy}, 32'd0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", {16'd0, bus_if.result}, {16'd0, e.result});
        checkOutput("cout", {31'd0, bus_if.cout}, {31'd0, e.cout});
        checkOutput("ovf", {31'd0, bus_if.ovf}, {31'd0, e.ovf});
      end
    end
  end

  // Check that every visible output is cleared.
  task automatic checkCleared(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, bus_if.done}, 32'd0);
    checkOutput({tag, "_result"}, {16'd0, bus_if.result}, 32'd0);
    checkOutput({tag, "_cout"}, {31'd0, bus_if.cout}, 32'd0);
    checkOutput({tag, "_ovf"}, {31'd0, bus_if.ovf}, 32'd0);
  endtask

  // Main test sequence.
  initial begin
    int bc;
    int dc_before;
    tests_run    = 0;
    tests_failed = 0;
    done_count   = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.cin   = 1'b0;
    bus_if.a_in  = '0;
    bus_if.b_in  = '0;
    #1;
    checkCleared("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
    runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
    runOp(16'h7FFF, 16'h0000, 1'b1, 1'b0, "add_ovf");
    runOp(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
    runOp(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");

    // start pulsed during RUN must be ignored
    dc_before = done_count;
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus_if.a_in  = 16'hABCD;
    bus_if.b_in  = 16'h5A5A;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    waitDone(bc);
    repeat (6) @(negedge clk);
    checkOutput("run_start_ignored_pulses", 32'(done_count - dc_before), 32'd1);

    // asynchronous reset mid-operation (result is nonzero beforehand)
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCleared("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    runOp(16'h0001, 16'h0002, 1'b0, 1'b0, "after_reset");

    // back-to-back: start accepted in DONE, no IDLE gap
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    waitDone(bc);
    bus_if.a_in  = 16'h00FF;
    bus_if.b_in  = 16'h0001;
    bus_if.cin   = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    sb_q.push_back(computeExp(16'h00FF, 16'h0001, 1'b0, 1'b0));
    #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy", {31'd0, bus_if.busy}, 32'd1);
    checkOutput("b2b_hold", {16'd0, bus_if.result}, 32'h2345);
    waitDone(bc);
    checkOutput("b2b_busy_len", 32'(bc), 32'd3);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
